// File: rtl/set_cmp_pkg.sv
// Shared types for the set-on-compare pipeline: compare opcodes, the flag
// bundle and the opcode width.
package set_cmp_pkg;

    localparam int SET_CMP_OP_W = 2;

    typedef enum logic [SET_CMP_OP_W-1:0] {
        SET_CMP_SLT  = 2'd0,
        SET_CMP_SLTU = 2'd1,
        SET_CMP_SEQ  = 2'd2,
        SET_CMP_SNE  = 2'd3
    } set_cmp_op_e;

    typedef struct packed {
        logic z;
        logic o;
        logic c;
        logic n;
    } set_cmp_flags_t;

endpackage

// File: rtl/set_cmp_pipe_if.sv
// Operand/result handshake bundle for set_cmp_pipe. The master drives
// operands and out_ready; the slave is the compare unit.
interface set_cmp_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    import set_cmp_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_a;
    logic [WIDTH-1:0]        in_b;
    logic [SET_CMP_OP_W-1:0] in_op;
    logic [TAG_W-1:0]        in_tag;

    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_result;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_z;
    logic                    out_o;
    logic                    out_c;
    logic                    out_n;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_z, out_o, out_c, out_n
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_z, out_o, out_c, out_n
    );

endinterface

// File: rtl/set_cmp_stage.sv
// Generic valid/ready register slice: holds one beat, accepts a new one
// whenever it is empty or its current beat is being taken downstream.
module set_cmp_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_d, valid_q;
    logic [DW-1:0] data_d,  data_q;
    logic          advance;

    assign advance  = !valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/set_cmp_pipe.sv
// Pipelined set-on-compare unit (SLT/SLTU/SEQ/SNE) with Z/O/C/N flags.
// Define SET_CMP_REGOUT_EN to add a registered output stage (latency 2).
module set_cmp_pipe
    import set_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    set_cmp_pipe_if.slave bus
);

    typedef struct packed {
        logic [WIDTH:0]          diff;
        logic                    sign_a;
        logic                    sign_b;
        logic [SET_CMP_OP_W-1:0] op;
        logic [TAG_W-1:0]        tag;
    } s1_t;

    typedef struct packed {
        logic             cond;
        set_cmp_flags_t   flags;
        logic [TAG_W-1:0] tag;
    } res_t;

    s1_t  s1_in, s1_out;
    logic s1_valid, s1_out_ready;
    res_t dec, res_out;
    logic res_valid;
    logic flag_n, flag_c, flag_o, is_eq, cond;

    // Subtract with an extra top bit so the borrow doubles as the unsigned compare.
    always_comb begin
        s1_in        = '0;
        s1_in.diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        s1_in.sign_a = bus.in_a[WIDTH-1];
        s1_in.sign_b = bus.in_b[WIDTH-1];
        s1_in.op     = bus.in_op;
        s1_in.tag    = bus.in_tag;
    end

    set_cmp_stage #(.DW($bits(s1_t))) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s1_out_ready),
        .out_data  (s1_out)
    );

    always_comb begin
        flag_n = s1_out.diff[WIDTH-1];
        flag_c = s1_out.diff[WIDTH];
        flag_o = (s1_out.sign_a != s1_out.sign_b) && (flag_n != s1_out.sign_a);
        is_eq  = (s1_out.diff[WIDTH-1:0] == '0);
        cond   = 1'b0;
        case (set_cmp_op_e'(s1_out.op))
            SET_CMP_SLT:  cond = flag_n ^ flag_o;
            SET_CMP_SLTU: cond = flag_c;
            SET_CMP_SEQ:  cond = is_eq;
            SET_CMP_SNE:  cond = !is_eq;
            default:      cond = 1'b0;
        endcase
        dec         = '0;
        dec.cond    = cond;
        dec.flags.z = !cond;
        dec.flags.o = flag_o;
        dec.flags.c = flag_c;
        dec.flags.n = flag_n;
        dec.tag     = s1_out.tag;
    end

`ifdef SET_CMP_REGOUT_EN
    set_cmp_stage #(.DW($bits(res_t))) u_stage_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s1_out_ready),
        .in_data   (dec),
        .out_valid (res_valid),
        .out_ready (bus.out_ready),
        .out_data  (res_out)
    );
`else
    // An idle stage-1 register would decode as z=1; force idle outputs to zero.
    assign s1_out_ready = bus.out_ready;
    assign res_valid    = s1_valid;
    assign res_out      = s1_valid ? dec : '0;
`endif

    assign bus.out_valid  = res_valid;
    assign bus.out_result = {{(WIDTH-1){1'b0}}, res_out.cond};
    assign bus.out_tag    = res_out.tag;
    assign bus.out_z      = res_out.flags.z;
    assign bus.out_o      = res_out.flags.o;
    assign bus.out_c      = res_out.flags.c;
    assign bus.out_n      = res_out.flags.n;

endmodule

// File: doc/set_cmp_pipe.md
# set_cmp_pipe

Pipelined, parametrised set-on-compare unit for the CPU execute stage. It takes two WIDTH-bit operands plus a compare opcode and produces a WIDTH-bit 0/1 result with Z/O/C/N flags. Operands and results move over valid/ready handshakes, and a writeback tag travels alongside each result. It replaces the single-cycle signed set-less-than path and adds unsigned, equal and not-equal compares, backpressure and in-order result delivery.

## Interface
- WIDTH, 32, operand and result width (>= 2)
- TAG_W, 5, width of the passthrough tag (destination register index)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domains
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts the beat this cycle
- in_a  input  WIDTH  operand A (rs)
- in_b  input  WIDTH  operand B (rt)
- in_op  input  2  opcode: 0 SLT (signed), 1 SLTU (unsigned), 2 SEQ, 3 SNE
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- out_result  output  WIDTH  {WIDTH-1 zeros, cond}
- out_tag  output  TAG_W  tag of the result
- out_z, out_o, out_c, out_n  output  1 each  result flags

## Operation
- Stage 1 registers diff = {1'b0,A} - {1'b0,B} (WIDTH+1 bits), sign(A), sign(B), op and tag.
- Flags are derived from the stage-1 register:
  - n = diff[WIDTH-1]
  - c = diff[WIDTH] (borrow, A <u B)
  - o = (signA != signB) && (n != signA)
  - eq = (diff[WIDTH-1:0] == 0)
- cond by op: SLT = n ^ o; SLTU = c; SEQ = eq; SNE = !eq.
- Flag outputs: out_z = !cond. out_n, out_c and out_o report the subtraction flags for every op.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Once out_valid is high, out_result, out_tag and the flags stay stable until the beat transfers.
  - in_ready must not depend combinationally on in_valid.
- Each stage holds its valid bit.
  - Stage k advances when it is empty, or when the stage after it advances (for the last stage: out_ready).
  - in_ready = stage-1 advance condition.
  - A full pipe with out_ready high accepts and emits one beat per cycle.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Reset, including mid-operation: every valid bit clears immediately (asynchronous) and every data register clears to 0.
  - Reset values: out_valid=0, out_result=0, out_tag=0, all flags 0.
  - in_ready reads 1 once rst_n is high.
  - In-flight beats are discarded. Nothing is emitted after release until new input arrives.

## Timing
- Latency from accept edge to out_valid: 1 cycle without SET_CMP_REGOUT_EN, 2 cycles with it.
- Throughput is 1 beat/cycle with no bubbles under continuous out_ready.
- Capacity: 1 beat without the macro, 2 with it.
- in_ready falls in the cycle the pipe is full and out_ready is low. It rises in the same cycle out_ready rises (combinational through the advance chain).
- Simultaneous accept and emit on a full pipe is legal and keeps the occupancy constant.

## Configuration
- SET_CMP_REGOUT_EN defined:
  - Adds an output register stage holding cond, flags and tag.
  - Outputs are driven purely from flops. Latency 2, capacity 2.
- SET_CMP_REGOUT_EN undefined:
  - Result and flags are decoded combinationally from the stage-1 register.
  - out_valid = stage-1 valid. Latency 1, capacity 1.
- Function is identical in both builds; only latency and capacity differ.

## Structure
- Package set_cmp_pkg holds:
  - op enum (SET_CMP_SLT, SET_CMP_SLTU, SET_CMP_SEQ, SET_CMP_SNE)
  - flag struct {z,o,c,n}
  - op width constant
- Sub-module set_cmp_stage: a generic valid/ready register slice (data width parameter, async active-low clear). It is instantiated once for stage 1 and once more under SET_CMP_REGOUT_EN.

## Test plan
- SLT, A=0xFFFFFFFF, B=0x00000001 -> out_result=1, z=0, n=1, o=0, c=0; SLTU on the same operands -> result=0, z=1, c=0.
- SLT, A=0x80000000, B=0x00000001 -> diff=0x7FFFFFFF, n=0, o=1, result=1; SLTU -> result=0.
- SEQ, A=B=0x00001234 -> result=1, z=0; SNE -> result=0, z=1; SLTU, A=0, B=1 -> c=1, result=1.
- Tags 1,2,3 offered back-to-back while out_ready=0 for 5 cycles:
  - With the macro, 2 beats are accepted and in_ready=0 while the third is offered.
  - Without it, 1 beat is accepted.
  - Outputs hold stable. After out_ready=1, tags emerge 1,2,3 on consecutive cycles.
- Continuous stream of 16 random beats with out_ready=1 -> one result per cycle after the stated latency, all matching the reference model.
- rst_n pulsed low mid-cycle with 2 beats in flight -> out_valid drops asynchronously with outputs at 0. After release, no result appears until a new beat is accepted.
